// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing constants and counter widths for the video timing generator.
package video_timing_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t TIMING_720P = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
  };

  localparam timing_t TIMING_480P = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster outputs plus advance enable, grouped for the generator and its consumers.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic                en_in;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic                hsync_out;
  logic                vsync_out;
  logic                ad_out;
  logic                nf_out;
  logic [5:0]          fc_out;

  modport master (
    input  en_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, ad_out, nf_out, fc_out
  );

  modport slave (
    output en_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, ad_out, nf_out, fc_out
  );

endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with sync/active flags decoded from the next count,
// so flags and count change on the same edge. Sync is raw active-high; polarity is applied above.
module sync_axis_counter #(
  parameter int ACTIVE = 1280,
  parameter int FP     = 110,
  parameter int SYNC   = 40,
  parameter int BP     = 220,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_in,
  output logic [W-1:0] count_out,
  output logic         wrap_out,
  output logic         sync_out,
  output logic         active_out
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  generate
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_param
      $error("sync_axis_counter: every active/porch/sync parameter must be >= 1");
    end
    if (TOTAL > (1 << W)) begin : g_bad_total
      $error("sync_axis_counter: axis total does not fit the count width");
    end
  endgenerate

  logic [W-1:0] count_nxt;

  assign wrap_out = (count_out == LAST);

  always_comb begin
    count_nxt = count_out;
    if (step_in) begin
      count_nxt = wrap_out ? '0 : count_out + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out  <= LAST;
      sync_out   <= 1'b0;
      active_out <= 1'b0;
    end else begin
      count_out  <= count_nxt;
      sync_out   <= (count_nxt >= SYNC_START) && (count_nxt < SYNC_END);
      active_out <= (count_nxt < ACT_END);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs with selectable polarity, active draw,
// one-cycle new-frame pulse and modulo-64 frame counter. en_in low freezes everything but nf.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = TIMING_720P.h_active,
  parameter int H_FP     = TIMING_720P.h_fp,
  parameter int H_SYNC   = TIMING_720P.h_sync,
  parameter int H_BP     = TIMING_720P.h_bp,
  parameter int V_ACTIVE = TIMING_720P.v_active,
  parameter int V_FP     = TIMING_720P.v_fp,
  parameter int V_SYNC   = TIMING_720P.v_sync,
  parameter int V_BP     = TIMING_720P.v_bp,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  video_timing_gen_if.master  vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HCOUNT_W-1:0] H_PRE_BLANK = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_BLANK     = VCOUNT_W'(V_ACTIVE);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end
  endgenerate

  logic h_wrap, v_wrap;
  logic h_sync_raw, v_sync_raw;
  logic h_act, v_act;
  logic frame_start;

  sync_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HCOUNT_W)
  ) u_h_axis (
    .clk        (pixel_clk_in),
    .rst_n      (rst_n_in),
    .step_in    (vt.en_in),
    .count_out  (vt.hcount_out),
    .wrap_out   (h_wrap),
    .sync_out   (h_sync_raw),
    .active_out (h_act)
  );

  sync_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VCOUNT_W)
  ) u_v_axis (
    .clk        (pixel_clk_in),
    .rst_n      (rst_n_in),
    .step_in    (vt.en_in && h_wrap),
    .count_out  (vt.vcount_out),
    .wrap_out   (v_wrap),
    .sync_out   (v_sync_raw),
    .active_out (v_act)
  );

  assign vt.hsync_out = SYNC_POL ? h_sync_raw : ~h_sync_raw;
  assign vt.vsync_out = SYNC_POL ? v_sync_raw : ~v_sync_raw;
  assign vt.ad_out    = h_act && v_act;

  // The edge that moves to (H_ACTIVE, V_ACTIVE) never wraps h, so v is already final here.
  assign frame_start = vt.en_in && (vt.hcount_out == H_PRE_BLANK) && (vt.vcount_out == V_BLANK);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vt.nf_out <= 1'b0;
      vt.fc_out <= '0;
    end else begin
      vt.nf_out <= frame_start;
      if (frame_start) begin
        vt.fc_out <= vt.fc_out + 6'd1;
      end
    end
  end

  frame_wrap_to_origin: assert property (@(posedge pixel_clk_in) disable iff (!rst_n_in)
      (vt.en_in && h_wrap && v_wrap) |=> (vt.hcount_out == '0 && vt.vcount_out == '0));

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench: three generators (720p, tiny, tiny with low syncs) against a frame-position model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if vif0 ();
  video_timing_gen_if vif1 ();
  video_timing_gen_if vif2 ();

  bit en_q [3];
  assign vif0.en_in = en_q[0];
  assign vif1.en_in = en_q[1];
  assign vif2.en_in = en_q[2];

  video_timing_gen u_dut0 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vt           (vif0)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_dut1 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vt           (vif1)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut2 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vt           (vif2)
  );

  // Reference: a linear pixel index within the frame plus a count of frame starts.
  typedef struct {
    int ha, hf, hsw, hb;
    int va, vf, vsw, vb;
    bit pol;
    int p;
    int frames;
    bit nf;
  } model_t;

  model_t m [3];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int h_total(input int k);
    return m[k].ha + m[k].hf + m[k].hsw + m[k].hb;
  endfunction

  function automatic int v_total(input int k);
    return m[k].va + m[k].vf + m[k].vsw + m[k].vb;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m[k].p      = h_total(k) * v_total(k) - 1;
      m[k].frames = 0;
      m[k].nf     = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    if (en_q[k]) begin
      m[k].p  = (m[k].p + 1) % (h_total(k) * v_total(k));
      m[k].nf = (m[k].p == m[k].va * h_total(k) + m[k].ha);
      if (m[k].nf) m[k].frames++;
    end else begin
      m[k].nf = 1'b0;
    end
  endtask

  task automatic observe(input int k, output int oh, output int ov, output int ohs,
                         output int ovs, output int oad, output int onf, output int ofc);
    case (k)
      0: begin
        oh = vif0.hcount_out; ov = vif0.vcount_out; ohs = vif0.hsync_out; ovs = vif0.vsync_out;
        oad = vif0.ad_out; onf = vif0.nf_out; ofc = vif0.fc_out;
      end
      1: begin
        oh = vif1.hcount_out; ov = vif1.vcount_out; ohs = vif1.hsync_out; ovs = vif1.vsync_out;
        oad = vif1.ad_out; onf = vif1.nf_out; ofc = vif1.fc_out;
      end
      default: begin
        oh = vif2.hcount_out; ov = vif2.vcount_out; ohs = vif2.hsync_out; ovs = vif2.vsync_out;
        oad = vif2.ad_out; onf = vif2.nf_out; ofc = vif2.fc_out;
      end
    endcase
  endtask

  task automatic check_dut(input int k);
    int h, v, hs_e, vs_e, ad_e;
    int oh, ov, ohs, ovs, oad, onf, ofc;
    h = m[k].p % h_total(k);
    v = m[k].p / h_total(k);
    hs_e = (h >= m[k].ha + m[k].hf && h < m[k].ha + m[k].hf + m[k].hsw) ? 1 : 0;
    vs_e = (v >= m[k].va + m[k].vf && v < m[k].va + m[k].vf + m[k].vsw) ? 1 : 0;
    if (!m[k].pol) begin
      hs_e = 1 - hs_e;
      vs_e = 1 - vs_e;
    end
    ad_e = (h < m[k].ha && v < m[k].va) ? 1 : 0;
    observe(k, oh, ov, ohs, ovs, oad, onf, ofc);
    chk($sformatf("dut%0d.hcount", k), oh, h);
    chk($sformatf("dut%0d.vcount", k), ov, v);
    chk($sformatf("dut%0d.hsync", k), ohs, hs_e);
    chk($sformatf("dut%0d.vsync", k), ovs, vs_e);
    chk($sformatf("dut%0d.ad", k), oad, ad_e);
    chk($sformatf("dut%0d.nf", k), onf, int'(m[k].nf));
    chk($sformatf("dut%0d.fc", k), ofc, m[k].frames % 64);
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    check_all();
  endtask

  initial begin
    int n, hs_cnt, hold_left, nf_cnt, nf_run, nf_max, prev_fc, wrap_seen;
    bit held;

    m[0] = '{ha:1280, hf:110, hsw:40, hb:220, va:720, vf:5, vsw:5, vb:20, pol:1'b1,
             p:0, frames:0, nf:1'b0};
    m[1] = '{ha:4, hf:1, hsw:1, hb:1, va:3, vf:1, vsw:1, vb:1, pol:1'b1,
             p:0, frames:0, nf:1'b0};
    m[2] = '{ha:4, hf:1, hsw:1, hb:1, va:3, vf:1, vsw:1, vb:1, pol:1'b0,
             p:0, frames:0, nf:1'b0};
    for (int k = 0; k < 3; k++) en_q[k] = 1'b0;
    model_reset();

    // Reset values, then release with enable high and look again before the first edge.
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) en_q[k] = 1'b1;
    #1;
    check_all();
    step();

    // Line 0 of 720p with a 10-cycle pause inside hsync at h = 1400.
    n = 0; hs_cnt = 0; hold_left = 0; held = 1'b0;
    while (m[0].p != h_total(0) && n < 3000) begin
      step();
      n++;
      if (vif0.hsync_out && vif0.vcount_out == 0) hs_cnt++;
      if (!held && m[0].p == 1400) begin
        en_q[0] = 1'b0; hold_left = 10; held = 1'b1;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) en_q[0] = 1'b1;
      end
    end
    chk("line_period", n, 1660);
    chk("hsync_width_stretched", hs_cnt, 50);

    // Fresh start for the small raster; 65 frames with random enable and a pause on nf.
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) en_q[k] = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; nf_cnt = 0; nf_run = 0; nf_max = 0; prev_fc = 0; wrap_seen = 0;
    hold_left = 0; held = 1'b0;
    while (m[1].frames < 65 && n < 10000) begin
      if (hold_left == 0) en_q[1] = ($urandom_range(3, 0) != 0);
      en_q[2] = ($urandom_range(3, 0) != 0);
      step();
      n++;
      if (vif1.nf_out) begin
        nf_cnt++; nf_run++;
        if (nf_run > nf_max) nf_max = nf_run;
      end else begin
        nf_run = 0;
      end
      if (prev_fc == 63 && vif1.fc_out == 0) wrap_seen++;
      prev_fc = vif1.fc_out;
      if (hold_left > 0) begin
        hold_left--;
      end else if (!held && m[1].nf) begin
        en_q[1] = 1'b0; hold_left = 10; held = 1'b1;
      end
    end
    chk("nf_pulse_count", nf_cnt, 65);
    chk("nf_pulse_len", nf_max, 1);
    chk("fc_wrap_63_to_0", wrap_seen, 1);
    chk("fc_after_65", vif1.fc_out, 1);

    // Asynchronous reset mid-frame once the small raster has counted 5 frames.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) en_q[k] = 1'b1;
    n = 0;
    while (!(m[1].frames == 5 && m[1].p == 2 * h_total(1) + 2) && n < 1000) begin
      step();
      n++;
    end
    chk("fc_before_reset", vif1.fc_out, 5);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
